// File: rtl/dmem_pkg.sv
// Shared encodings and types for the data-memory responder.
package dmem_pkg;

  // Access size encodings on req_size; 2'b11 is handled as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Largest supported access latency and the counter width that holds it.
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Request fields captured at the accept edge.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for loads and stores: byte enables, replicated store
// data, load extraction with sign/zero extension, and a misalignment flag.
// Misaligned halves/words are force-aligned here; the caller decides whether
// the flag turns into an error.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [1:0]  lo;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Lane select per size; store data is replicated so any enabled lane
  // already carries the right bits.
  always_comb begin
    lo        = addr_lo;
    be        = 4'b0000;
    wdata_sh  = wdata;
    rdata_ext = rword;
    misalign  = 1'b0;
    rbyte     = 8'h00;
    rhalf     = 16'h0000;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lo;
        wdata_sh  = {4{wdata[7:0]}};
        rbyte     = rword[{lo, 3'b000} +: 8];
        rdata_ext = {{24{~is_unsigned & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        misalign  = addr_lo[0];
        lo        = {addr_lo[1], 1'b0};
        be        = lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rhalf     = lo[1] ? rword[31:16] : rword[15:0];
        rdata_ext = {{16{~is_unsigned & rhalf[15]}}, rhalf};
      end
      default: begin
        misalign  = |addr_lo;
        lo        = 2'b00;
        be        = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store per handshake, waits a fixed
// LATENCY (1..LAT_MAX), then pulses resp_valid for one cycle. Stores commit
// on the edge leaving RESP; loads read the array during RESP.
// Optional build macro DMEM_MISALIGN_CHK_EN: misaligned or read+write
// requests are suppressed and flagged on resp_err. Without it, misaligned
// accesses are force-aligned and resp_err is tied low.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  req_t             req_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic [31:0]      rword, wdata_sh, rdata_ext;
  logic [3:0]       be;
  logic             misalign, accept, both, bad, store_ok, load_ok;

  // Upper address bits wrap; they are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^req_q.addr[31:IDX_W+2];

  assign idx    = req_q.addr[IDX_W+1:2];
  assign rword  = mem[idx];
  assign accept = (state_q == ST_IDLE) & req_valid & (req_read | req_write);
  assign both   = req_q.rd & req_q.wr;

`ifdef DMEM_MISALIGN_CHK_EN
  assign bad = both | misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign bad = both;
`endif

  assign store_ok = req_q.wr & ~bad;
  assign load_ok  = req_q.rd & ~bad;

  dmem_lane_align u_align (
    .size        (req_q.size),
    .addr_lo     (req_q.addr[1:0]),
    .is_unsigned (req_q.uns),
    .wdata       (req_q.wdata),
    .rword       (rword),
    .be          (be),
    .wdata_sh    (wdata_sh),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  // State register, latency counter and request capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CNT_W'(LATENCY - 1);
        req_q <= '{rd: req_read, wr: req_write, size: req_size,
                   uns: req_unsigned, addr: req_addr, wdata: req_wdata};
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Next state and handshake/response outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept) state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = load_ok ? rdata_ext : 32'h0;
`ifdef DMEM_MISALIGN_CHK_EN
        resp_err   = bad;
`endif
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Store commit on the edge leaving RESP; only enabled lanes change.
  always_ff @(posedge clk) begin
    if (state_q == ST_RESP && store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table of request vectors with expected
// responses, scoreboard queue checked by a response monitor, plus
// reset-mid-store and ignored-request sequences.
module tb_data_mem_responder;

  localparam int LAT = 2;
`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       nm;
  } exp_t;

  typedef struct {
    string       nm;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] er;
    bit          ee;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] sz, input bit uns,
                     input logic [31:0] er, input bit ee);
    vec_t v;
    v.nm = nm; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
    v.sz = sz; v.uns = uns; v.er = er; v.ee = ee;
    vecs.push_back(v);
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", {31'b0, resp_valid}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.nm, "_rdata"}, resp_rdata, mon_e.rdata);
        chk({mon_e.nm, "_err"}, {31'b0, resp_err}, {31'b0, mon_e.err});
        chk({mon_e.nm, "_cyc"}, cyc, mon_e.cyc);
      end
    end
  end

  task automatic xact(input vec_t v);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_read = v.rd; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_size = v.sz; req_unsigned = v.uns;
    @(posedge clk); #1;
    e.rdata = v.er; e.err = v.ee; e.cyc = cyc + LAT - 1; e.nm = v.nm;
    sb.push_back(e);
    // Scramble inputs: only the accept-edge values may matter.
    req_valid = 1'b0; req_read = 1'($urandom); req_write = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
    @(negedge clk);
    chk({v.nm, "_busy"}, {31'b0, req_ready}, 32'h0);
    for (int i = 0; i < 4 * LAT + 8 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk({v.nm, "_timeout"}, sb.size(), 32'h0);
      sb.delete();
    end
    @(negedge clk);
    chk({v.nm, "_ready"}, {31'b0, req_ready}, 32'h1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int nresp;
    vec_t v;

    add("st_w10",     0, 1, 32'h10,   32'hDEADBEEF, 2'b10, 0, 32'h0, 0);
    add("ld_w10",     1, 0, 32'h10,   32'h0,        2'b10, 0, 32'hDEADBEEF, 0);
    add("ld_b13s",    1, 0, 32'h13,   32'h0,        2'b00, 0, 32'hFFFFFFDE, 0);
    add("st_w20",     0, 1, 32'h20,   32'h0,        2'b10, 0, 32'h0, 0);
    add("st_b23",     0, 1, 32'h23,   32'h80,       2'b00, 0, 32'h0, 0);
    add("ld_b23s",    1, 0, 32'h23,   32'h0,        2'b00, 0, 32'hFFFFFF80, 0);
    add("ld_b23u",    1, 0, 32'h23,   32'h0,        2'b00, 1, 32'h00000080, 0);
    add("st_h22",     0, 1, 32'h22,   32'h1234,     2'b01, 0, 32'h0, 0);
    add("ld_w20",     1, 0, 32'h20,   32'h0,        2'b10, 0, 32'h12340000, 0);
    add("ld_h22s",    1, 0, 32'h22,   32'h0,        2'b01, 0, 32'h00001234, 0);
    add("st_w20b",    0, 1, 32'h20,   32'hCAFEF00D, 2'b10, 0, 32'h0, 0);
    add("ld_mis_w21", 1, 0, 32'h21,   32'h0,        2'b10, 0, CHK ? 32'h0 : 32'hCAFEF00D, CHK);
    add("st_mis_w21", 0, 1, 32'h21,   32'h12345678, 2'b10, 0, 32'h0, CHK);
    add("ld_w20c",    1, 0, 32'h20,   32'h0,        2'b10, 0, CHK ? 32'hCAFEF00D : 32'h12345678, 0);
    add("ld_mis_h23", 1, 0, 32'h23,   32'h0,        2'b01, 1, CHK ? 32'h0 : 32'h00001234, CHK);
    add("st_w30",     0, 1, 32'h30,   32'h0,        2'b10, 0, 32'h0, 0);
    add("both_30",    1, 1, 32'h30,   32'h55,       2'b10, 0, 32'h0, CHK);
    add("ld_w30",     1, 0, 32'h30,   32'h0,        2'b10, 0, 32'h0, 0);
    add("st_w50",     0, 1, 32'h50,   32'h8001FFFF, 2'b10, 0, 32'h0, 0);
    add("ld_h52s",    1, 0, 32'h52,   32'h0,        2'b01, 0, 32'hFFFF8001, 0);
    add("ld_h50u",    1, 0, 32'h50,   32'h0,        2'b01, 1, 32'h0000FFFF, 0);
    add("ld_b51u",    1, 0, 32'h51,   32'h0,        2'b00, 1, 32'h000000FF, 0);
    add("st_b51",     0, 1, 32'h51,   32'hAB,       2'b00, 0, 32'h0, 0);
    add("ld_w50",     1, 0, 32'h50,   32'h0,        2'b10, 0, 32'h8001ABFF, 0);
    add("st_wrap",    0, 1, 32'h1000, 32'hA5A5A5A5, 2'b10, 0, 32'h0, 0);
    add("ld_wrap0",   1, 0, 32'h0,    32'h0,        2'b10, 0, 32'hA5A5A5A5, 0);
    add("ld_sz11",    1, 0, 32'h0,    32'h0,        2'b11, 1, 32'hA5A5A5A5, 0);
    add("st_w40",     0, 1, 32'h40,   32'h0,        2'b10, 0, 32'h0, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'b0, resp_err}, 32'h0);
    reset = 1'b1;

    foreach (vecs[i]) xact(vecs[i]);

    // Reset asserted while a store waits: no response, no commit.
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_addr = 32'h40;
    req_wdata = 32'h11111111; req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    @(negedge clk);
    chk("mid_busy", {31'b0, req_ready}, 32'h0);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, resp_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_ready", {31'b0, req_ready}, 32'h1);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    v.nm = "ld_w40"; v.rd = 1; v.wr = 0; v.addr = 32'h40; v.wdata = 0;
    v.sz = 2'b10; v.uns = 0; v.er = 32'h0; v.ee = 0;
    xact(v);

    // Valid with no operation must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = 32'h10;
    nresp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) nresp++;
      chk("ign_ready", {31'b0, req_ready}, 32'h1);
    end
    chk("ign_nresp", nresp, 32'h0);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
